// File: rtl/loop_gain_pkg.sv
// Shared definitions for the loop-gain injection / detection blocks.
package loop_gain_pkg;

  // Defaults shared with the NCO / injector block.
  localparam int DEF_W      = 12;
  localparam int DEF_N_LOG2 = 10;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    ACCUM  = 2'd2,
    DONE   = 2'd3
  } state_t;

  // Accumulator width: one W x W product needs 2W bits; summing 2^n_log2 of
  // them adds n_log2 bits, which also covers (-2^(W-1))^2 * 2^n_log2.
  function automatic int acc_width(input int w, input int n_log2);
    return 2 * w + n_log2;
  endfunction

endpackage

// File: rtl/loop_gain_detector_iq_mac.sv
// Signed W x W multiply with sign-extended accumulate; clear wins over enable.
// sum is the running total including the current product, so the caller can
// capture the final value on the same edge the last sample is accumulated.
module iq_mac #(
  parameter int W     = 12,
  parameter int ACC_W = 34
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  input  logic [W-1:0]     a,
  input  logic [W-1:0]     b,
  output logic [ACC_W-1:0] sum
);

  logic signed [2*W-1:0] a_x, b_x, prod;
  logic [ACC_W-1:0]      acc;

  // Operands widened first so the low 2W bits hold the exact signed product.
  assign a_x  = {{W{a[W-1]}}, a};
  assign b_x  = {{W{b[W-1]}}, b};
  assign prod = a_x * b_x;
  assign sum  = acc + {{(ACC_W-2*W){prod[2*W-1]}}, prod};

  // Accumulator register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)      acc <= '0;
    else if (clr) acc <= '0;
    else if (en)  acc <= sum;
  end

endmodule

// File: rtl/loop_gain_detector.sv
// Correlates both probe-node ADC streams against the NCO cos/sin over a
// 2^N_LOG2 sample window, after discarding settle_cnt samples.
module loop_gain_detector
  import loop_gain_pkg::*;
#(
  parameter int  W        = DEF_W,
  parameter int  N_LOG2   = DEF_N_LOG2,
  parameter int  SETTLE_W = 8,
  localparam int ACC_W    = acc_width(W, N_LOG2)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                abort,
  input  logic [SETTLE_W-1:0] settle_cnt,
  input  logic                s_valid,
  output logic                s_ready,
  input  logic [W-1:0]        adc_in,
  input  logic [W-1:0]        adc_out,
  input  logic [W-1:0]        ref_cos,
  input  logic [W-1:0]        ref_sin,
  output logic                r_valid,
  input  logic                r_ready,
  output logic [ACC_W-1:0]    i_in,
  output logic [ACC_W-1:0]    q_in,
  output logic [ACC_W-1:0]    i_out,
  output logic [ACC_W-1:0]    q_out,
  output logic                in_zero,
  output logic                busy
);

  // Sample counter is one bit wider than the window index so it never wraps.
  localparam logic [N_LOG2:0]   CNT_ONE  = (N_LOG2+1)'(1);
  localparam logic [N_LOG2:0]   CNT_LAST = (N_LOG2+1)'((1 << N_LOG2) - 1);
  localparam logic [SETTLE_W-1:0] SET_ONE = SETTLE_W'(1);

  state_t                state, state_nxt;
  logic [SETTLE_W-1:0]   settle_left;
  logic [N_LOG2:0]       samp_cnt;
  logic                  xfer, go, last, acc_en;

  logic [3:0][W-1:0]     mac_a, mac_b;
  logic [3:0][ACC_W-1:0] mac_sum;

  assign s_ready = (state == SETTLE) || (state == ACCUM);
  assign busy    = (state != IDLE);
  assign xfer    = s_valid && s_ready;
  assign acc_en  = xfer && (state == ACCUM);

  // Lane k: bit1 selects node (in/out), bit0 selects reference (cos/sin).
  // Order 0..3 = i_in, q_in, i_out, q_out.
  for (genvar k = 0; k < 4; k++) begin : g_mac
    assign mac_a[k] = (k < 2) ? adc_in : adc_out;
    assign mac_b[k] = (k % 2 == 0) ? ref_cos : ref_sin;

    iq_mac #(.W(W), .ACC_W(ACC_W)) u_mac (
      .clk (clk),
      .rst (rst),
      .clr (go),
      .en  (acc_en),
      .a   (mac_a[k]),
      .b   (mac_b[k]),
      .sum (mac_sum[k])
    );
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic; abort beats every other event, including start.
  always_comb begin
    state_nxt = state;
    go        = 1'b0;
    last      = 1'b0;
    case (state)
      IDLE: begin
        if (start && !abort) begin
          go        = 1'b1;
          state_nxt = (settle_cnt != '0) ? SETTLE : ACCUM;
        end
      end
      SETTLE: begin
        if (abort)                              state_nxt = IDLE;
        else if (xfer && settle_left == SET_ONE) state_nxt = ACCUM;
      end
      ACCUM: begin
        if (abort) state_nxt = IDLE;
        else if (xfer && samp_cnt == CNT_LAST) begin
          last      = 1'b1;
          state_nxt = DONE;
        end
      end
      DONE: begin
        if (abort || r_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Settle and sample counters; both hold through s_valid gaps.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      settle_left <= '0;
      samp_cnt    <= '0;
    end else if (go) begin
      settle_left <= settle_cnt;
      samp_cnt    <= '0;
    end else if (xfer) begin
      if (state == SETTLE) settle_left <= settle_left - SET_ONE;
      if (state == ACCUM)  samp_cnt    <= samp_cnt + CNT_ONE;
    end
  end

  // Result registers: loaded with the sums including the final sample, then
  // held (through backpressure and abort) until the next result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      i_in    <= '0;
      q_in    <= '0;
      i_out   <= '0;
      q_out   <= '0;
      in_zero <= 1'b0;
      r_valid <= 1'b0;
    end else if (last) begin
      i_in    <= mac_sum[0];
      q_in    <= mac_sum[1];
      i_out   <= mac_sum[2];
      q_out   <= mac_sum[3];
      in_zero <= (mac_sum[0] == '0) && (mac_sum[1] == '0);
      r_valid <= 1'b1;
    end else if (state == DONE && (abort || r_ready)) begin
      r_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_loop_gain_detector.sv
// Bench for loop_gain_detector: measurement-level model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_loop_gain_detector;

  localparam int W = 12, N_LOG2 = 2, SETTLE_W = 8, ACC_W = 26, N = 4;

  logic                clk = 1'b0, rst = 1'b1;
  logic                start, abort, s_valid, s_ready, r_valid, r_ready;
  logic                in_zero, busy;
  logic [SETTLE_W-1:0] settle_cnt;
  logic [W-1:0]        adc_in, adc_out, ref_cos, ref_sin;
  logic [ACC_W-1:0]    i_in, q_in, i_out, q_out;

  int pass_cnt = 0, total_cnt = 0;

  always #5 clk = ~clk;

  loop_gain_detector #(.W(W), .N_LOG2(N_LOG2), .SETTLE_W(SETTLE_W)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .settle_cnt(settle_cnt),
    .s_valid(s_valid), .s_ready(s_ready), .adc_in(adc_in), .adc_out(adc_out),
    .ref_cos(ref_cos), .ref_sin(ref_sin), .r_valid(r_valid), .r_ready(r_ready),
    .i_in(i_in), .q_in(q_in), .i_out(i_out), .q_out(q_out),
    .in_zero(in_zero), .busy(busy)
  );

  task automatic check(input string name, input longint act, input longint exp);
    total_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  function automatic longint sx(input logic [W-1:0] v);
    return longint'($signed(v));
  endfunction

  function automatic longint sa(input logic [ACC_W-1:0] v);
    return longint'($signed(v));
  endfunction

  // ---------------- behavioural model ----------------
  // phase: 0 idle, 1 discarding, 2 collecting, 3 result pending
  int     m_phase = 0, m_settle = 0;
  longint win[$];
  longint m_out[4];
  bit     m_rv = 0, m_zero = 0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_phase = 0; m_settle = 0; m_rv = 0; m_zero = 0;
      win.delete();
      for (int k = 0; k < 4; k++) m_out[k] = 0;
    end else begin
      case (m_phase)
        0: if (start && !abort) begin
             win.delete();
             m_settle = int'(settle_cnt);
             m_phase  = (m_settle != 0) ? 1 : 2;
           end
        1: if (abort) m_phase = 0;
           else if (s_valid) begin
             m_settle--;
             if (m_settle == 0) m_phase = 2;
           end
        2: if (abort) m_phase = 0;
           else if (s_valid) begin
             // window stored as 4 products per sample; summed at completion
             win.push_back(sx(adc_in)  * sx(ref_cos));
             win.push_back(sx(adc_in)  * sx(ref_sin));
             win.push_back(sx(adc_out) * sx(ref_cos));
             win.push_back(sx(adc_out) * sx(ref_sin));
             if (win.size() == 4 * N) begin
               for (int k = 0; k < 4; k++) begin
                 m_out[k] = 0;
                 for (int s = 0; s < N; s++) m_out[k] += win[4*s + k];
               end
               m_zero  = (m_out[0] == 0) && (m_out[1] == 0);
               m_rv    = 1;
               m_phase = 3;
             end
           end
        default: if (abort || r_ready) begin m_rv = 0; m_phase = 0; end
      endcase
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    check("busy",    longint'(busy),    longint'(m_phase != 0));
    check("s_ready", longint'(s_ready), longint'(m_phase == 1 || m_phase == 2));
    check("r_valid", longint'(r_valid), longint'(m_rv));
    check("i_in",    sa(i_in),  m_out[0]);
    check("q_in",    sa(q_in),  m_out[1]);
    check("i_out",   sa(i_out), m_out[2]);
    check("q_out",   sa(q_out), m_out[3]);
    check("in_zero", longint'(in_zero), longint'(m_zero));
  end

  // ---------------- directed helpers ----------------
  task automatic set_data(input int a, input int o, input int c, input int s);
    adc_in = 12'(a); adc_out = 12'(o); ref_cos = 12'(c); ref_sin = 12'(s);
  endtask

  // Called #1 after an edge; start is seen on the following edge.
  task automatic do_start(input int s);
    start = 1'b1; settle_cnt = 8'(s);
    @(posedge clk); #1 start = 1'b0;
  endtask

  // Waits for r_valid, counting cycles with a transfer-capable s_ready.
  task automatic wait_result(input int max_cyc, input bit toggle, input bit poke,
                             output int rdy);
    bit got = 0;
    rdy = 0;
    for (int c = 0; c < max_cyc && !got; c++) begin
      @(negedge clk);
      if (r_valid) got = 1;
      else begin
        if (s_ready && s_valid) rdy++;
        if (toggle) s_valid = ~s_valid;
        if (poke) start = (c == 0);
      end
    end
    start = 1'b0;
    check("result_timeout", longint'(got), 1);
  endtask

  task automatic release_result();
    @(posedge clk); #1 r_ready = 1'b1;
    @(posedge clk); #1 r_ready = 1'b0;
    @(negedge clk);
    check("released_busy", longint'(busy), 0);
  endtask

  int rdy, rv_seen;

  initial begin
    start = 0; abort = 0; settle_cnt = 0; s_valid = 0; r_ready = 0;
    set_data(0, 0, 0, 0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_busy",    longint'(busy), 0);
    check("rst_r_valid", longint'(r_valid), 0);
    check("rst_s_ready", longint'(s_ready), 0);
    check("rst_i_in",    sa(i_in), 0);

    // Basic accumulate, settle 2.
    @(posedge clk); #1 set_data(100, -200, 1000, 0); s_valid = 1'b1;
    do_start(2);
    wait_result(40, 0, 0, rdy);
    check("basic_ready_cycles", rdy, 6);
    check("basic_i_in",  sa(i_in), 400000);
    check("basic_q_in",  sa(q_in), 0);
    check("basic_i_out", sa(i_out), -800000);
    check("basic_q_out", sa(q_out), 0);
    check("basic_in_zero", longint'(in_zero), 0);
    release_result();

    // Worst-case magnitude, no settle.
    #1 set_data(-2048, -2048, -2048, -2048);
    do_start(0);
    wait_result(40, 0, 0, rdy);
    check("worst_ready_cycles", rdy, 4);
    check("worst_i_in",  sa(i_in),  16777216);
    check("worst_q_in",  sa(q_in),  16777216);
    check("worst_i_out", sa(i_out), 16777216);
    check("worst_q_out", sa(q_out), 16777216);
    release_result();

    // Gaps in s_valid and result backpressure.
    #1 set_data(100, -200, 1000, 0);
    do_start(2);
    wait_result(80, 1, 0, rdy);
    s_valid = 1'b1;
    check("gap_accepted", rdy, 6);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check("bp_r_valid", longint'(r_valid), 1);
      check("bp_i_in",  sa(i_in), 400000);
      check("bp_i_out", sa(i_out), -800000);
    end
    release_result();

    // Zero input node.
    #1 set_data(0, 50, 300, 300);
    do_start(1);
    wait_result(40, 0, 0, rdy);
    check("zero_in_zero", longint'(in_zero), 1);
    check("zero_i_in",  sa(i_in), 0);
    check("zero_i_out", sa(i_out), 60000);
    check("zero_q_out", sa(q_out), 60000);
    release_result();

    // Abort after two accumulated samples.
    #1 set_data(100, -200, 1000, 0);
    do_start(0);
    @(posedge clk); @(posedge clk); #1 abort = 1'b1;
    @(posedge clk); #1 abort = 1'b0;
    @(negedge clk);
    check("abort_busy",    longint'(busy), 0);
    check("abort_r_valid", longint'(r_valid), 0);
    // start together with abort stays idle
    @(posedge clk); #1 start = 1'b1; abort = 1'b1;
    @(posedge clk); #1 start = 1'b0; abort = 1'b0;
    @(negedge clk);
    check("start_abort_busy", longint'(busy), 0);
    // clean run with a stray start during accumulation
    @(posedge clk); #1 do_start(0);
    wait_result(40, 0, 1, rdy);
    check("restart_accepted", rdy, N);
    check("restart_i_in", sa(i_in), 400000);
    release_result();

    // Async reset in the middle of accumulation.
    #1 do_start(0);
    @(posedge clk); #3 rst = 1'b1;
    #1;
    check("arst_busy",    longint'(busy), 0);
    check("arst_r_valid", longint'(r_valid), 0);
    check("arst_i_in",    sa(i_in), 0);
    check("arst_s_ready", longint'(s_ready), 0);
    @(posedge clk); #1 rst = 1'b0;
    rv_seen = 0;
    repeat (10) begin @(negedge clk); if (r_valid) rv_seen++; end
    check("arst_no_result", rv_seen, 0);

    // Randomized traffic.
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk); #1;
      start      = ($urandom_range(0, 7) == 0);
      abort      = ($urandom_range(0, 59) == 0);
      settle_cnt = 8'($urandom_range(0, 3));
      s_valid    = ($urandom_range(0, 9) < 6);
      r_ready    = ($urandom_range(0, 2) == 0);
      adc_in     = 12'($urandom_range(0, 4095));
      adc_out    = 12'($urandom_range(0, 4095));
      ref_cos    = 12'($urandom_range(0, 4095));
      ref_sin    = 12'($urandom_range(0, 4095));
    end
    @(posedge clk); #1 start = 0; abort = 0; s_valid = 0; r_ready = 0;
    @(negedge clk);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
